// File: rtl/kypd_scan.sv
// kypd_scan: 4x4 matrix keypad scanner (Pmod KYPD layout) with frame-level debouncing.
//
// Drives one keypad column low at a time, samples the shared active-low row lines at the end
// of each column dwell, and classifies every full 4-column frame as no key, exactly one key,
// or several keys. A four-state debouncer accepts a key after DEBOUNCE_SCANS matching frames
// and releases it after DEBOUNCE_SCANS non-matching frames.
//
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   row_n[3:0] keypad rows, active-low, asynchronous to clk
//   col_n[3:0] keypad column drive, one-hot-low
//   key_code   hex value of the last accepted key
//   key_valid  one-cycle pulse per accepted press
//   key_held   high while the accepted key remains debounced-pressed
//   data_out   24-bit hex digit shift register (only with KYPD_HEX_SHIFT_EN, else 0)
//
// Optional feature macro: KYPD_HEX_SHIFT_EN
module kypd_scan #(
    parameter int unsigned SCAN_TICKS     = 25000,
    parameter int unsigned DEBOUNCE_SCANS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  row_n,
    output logic [3:0]  col_n,
    output logic [3:0]  key_code,
    output logic        key_valid,
    output logic        key_held,
    output logic [23:0] data_out
);

    localparam int unsigned DwellW = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
    localparam int unsigned CntW   = $clog2(DEBOUNCE_SCANS + 1);

    typedef enum logic [1:0] {StReleased, StPressDb, StHeld, StReleaseDb} state_e;

    logic [3:0]        row_meta_q, row_sync_q;
    logic [DwellW-1:0] dwell_q, dwell_d;
    logic [1:0]        col_idx_q, col_idx_d;
    logic [3:0]        col_n_q, col_n_d;
    logic [11:0]       frame_q, frame_d;
    state_e            state_q, state_d;
    logic [3:0]        cand_q, cand_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [3:0]        code_q, code_d;
    logic              held_q, held_d;
    logic              valid_q, valid_d;

    logic              tick_end, frame_done;
    logic [15:0]       frame_pressed;
    logic              is_key;
    logic [3:0]        cur_code;
    logic              cand_match, code_match;
    logic              accept, release_key;

    // Pressed-bit index is col*4+row.
    function automatic logic [3:0] key_map(input logic [3:0] idx);
        logic [3:0] code;
        case (idx)
            4'd0:  code = 4'h1;
            4'd1:  code = 4'h4;
            4'd2:  code = 4'h7;
            4'd3:  code = 4'h0;
            4'd4:  code = 4'h2;
            4'd5:  code = 4'h5;
            4'd6:  code = 4'h8;
            4'd7:  code = 4'hF;
            4'd8:  code = 4'h3;
            4'd9:  code = 4'h6;
            4'd10: code = 4'h9;
            4'd11: code = 4'hE;
            4'd12: code = 4'hA;
            4'd13: code = 4'hB;
            4'd14: code = 4'hC;
            default: code = 4'hD;
        endcase
        return code;
    endfunction

    // Scan timing and per-column row capture.
    always_comb begin
        tick_end  = (dwell_q == DwellW'(SCAN_TICKS - 1));
        dwell_d   = tick_end ? '0 : dwell_q + DwellW'(1);
        col_idx_d = col_idx_q;
        col_n_d   = col_n_q;
        frame_d   = frame_q;
        if (tick_end) begin
            col_idx_d = col_idx_q + 2'd1;
            col_n_d   = {col_n_q[2:0], col_n_q[3]};
            case (col_idx_q)
                2'd0:    frame_d[3:0]  = ~row_sync_q;
                2'd1:    frame_d[7:4]  = ~row_sync_q;
                2'd2:    frame_d[11:8] = ~row_sync_q;
                default: frame_d       = frame_q;
            endcase
        end
    end

    // Column 3 is folded in directly from the synchronizer so the frame result is registered
    // on the same edge that captures the last column.
    always_comb begin
        frame_done    = tick_end && (col_idx_q == 2'd3);
        frame_pressed = {~row_sync_q, frame_q};
        is_key        = $onehot(frame_pressed);
        cur_code      = 4'h0;
        for (int i = 0; i < 16; i++) begin
            if (frame_pressed[i]) begin
                cur_code = key_map(4'(i));
            end
        end
        cand_match = is_key && (cur_code == cand_q);
        code_match = is_key && (cur_code == code_q);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            row_meta_q <= 4'b1111;
            row_sync_q <= 4'b1111;
            dwell_q    <= '0;
            col_idx_q  <= 2'd0;
            col_n_q    <= 4'b1110;
            frame_q    <= '0;
            state_q    <= StReleased;
            cand_q     <= 4'h0;
            cnt_q      <= '0;
            code_q     <= 4'h0;
            held_q     <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            row_meta_q <= row_n;
            row_sync_q <= row_meta_q;
            dwell_q    <= dwell_d;
            col_idx_q  <= col_idx_d;
            col_n_q    <= col_n_d;
            frame_q    <= frame_d;
            state_q    <= state_d;
            cand_q     <= cand_d;
            cnt_q      <= cnt_d;
            code_q     <= code_d;
            held_q     <= held_d;
            valid_q    <= valid_d;
        end
    end

    // Debounce next state, advanced once per frame.
    always_comb begin
        state_d     = state_q;
        cand_d      = cand_q;
        cnt_d       = cnt_q;
        code_d      = code_q;
        held_d      = held_q;
        valid_d     = 1'b0;
        accept      = 1'b0;
        release_key = 1'b0;
        if (frame_done) begin
            unique case (state_q)
                StReleased: begin
                    if (is_key) begin
                        cand_d = cur_code;
                        cnt_d  = CntW'(1);
                        if (DEBOUNCE_SCANS == 1) accept = 1'b1;
                        else state_d = StPressDb;
                    end
                end
                StPressDb: begin
                    if (cand_match) begin
                        cnt_d = cnt_q + CntW'(1);
                        if (cnt_d == CntW'(DEBOUNCE_SCANS)) accept = 1'b1;
                    end else if (is_key) begin
                        cand_d = cur_code;
                        cnt_d  = CntW'(1);
                    end else begin
                        state_d = StReleased;
                        cnt_d   = '0;
                    end
                end
                StHeld: begin
                    if (code_match) begin
                        cnt_d = '0;
                    end else begin
                        cnt_d = CntW'(1);
                        if (DEBOUNCE_SCANS == 1) release_key = 1'b1;
                        else state_d = StReleaseDb;
                    end
                end
                StReleaseDb: begin
                    if (code_match) begin
                        state_d = StHeld;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                        if (cnt_d == CntW'(DEBOUNCE_SCANS)) release_key = 1'b1;
                    end
                end
                default: state_d = StReleased;
            endcase
            if (accept) begin
                code_d  = cand_d;
                valid_d = 1'b1;
                held_d  = 1'b1;
                state_d = StHeld;
                cnt_d   = '0;
            end
            if (release_key) begin
                held_d  = 1'b0;
                state_d = StReleased;
                cnt_d   = '0;
            end
        end
    end

    // Outputs.
    always_comb begin
        col_n     = col_n_q;
        key_code  = code_q;
        key_valid = valid_q;
        key_held  = held_q;
    end

`ifdef KYPD_HEX_SHIFT_EN
    logic [23:0] data_q, data_d;

    // Key E acts as a clear for the display word.
    always_comb begin
        data_d = data_q;
        if (accept) begin
            data_d = (cand_d == 4'hE) ? 24'h0 : {data_q[19:0], cand_d};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) data_q <= 24'h0;
        else     data_q <= data_d;
    end

    assign data_out = data_q;
`else
    assign data_out = 24'h0;
`endif

endmodule

// File: doc/kypd_scan.md
Name: kypd_scan

Overview:
- Scans a 4x4 matrix keypad (Pmod KYPD layout) and reports debounced hex key presses.
- Counterpart to the multiplexed 7-segment driver. That driver time-multiplexes outputs onto a shared bus; this block time-multiplexes column drives and reads the shared row lines back.
- Sits between the board pins and user logic. It can optionally feed a 24-bit hex word straight to the display driver's data input.

Parameters:
- SCAN_TICKS, 25000, clk cycles each column is driven before its rows are sampled; must be >= 4.
- DEBOUNCE_SCANS, 8, consecutive identical full frames needed to accept a press or a release; must be >= 1.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- row_n  input  4  keypad rows, active-low, externally pulled up; asynchronous to clk.
- col_n  output  4  keypad column drive, active-low, one-hot-low.
- key_code  output  4  hex value of the last accepted key.
- key_valid  output  1  one-cycle pulse when a new key is accepted.
- key_held  output  1  high while the accepted key is still debounced-pressed.
- data_out  output  24  hex digit shift register; present only with KYPD_HEX_SHIFT_EN, otherwise tied to 0.

Behaviour:
- Reset values (all applied on the clk edge while rst=1):
  - col_n=4'b1110; key_code=0; key_valid=0; key_held=0; data_out=0.
  - Dwell counter=0, column index=0, debounce counter=0, FSM=RELEASED, row synchronizer=4'b1111.
- Row input: row_n passes through a 2-flop synchronizer before use.
- Scan:
  - The dwell counter runs 0..SCAN_TICKS-1.
  - On the cycle it equals SCAN_TICKS-1:
    - the synchronized rows for the active column are captured;
    - the column index advances, 0->1->2->3->0;
    - col_n rotates 1110->1101->1011->0111->1110.
  - One frame is 4*SCAN_TICKS cycles.
- Key map (column, row -> code):
  - row0: c0=1, c1=2, c2=3, c3=A.
  - row1: c0=4, c1=5, c2=6, c3=B.
  - row2: c0=7, c1=8, c2=9, c3=C.
  - row3: c0=0, c1=F, c2=E, c3=D.
- Frame result, evaluated in the cycle after column 3 is captured:
  - NONE: no low row bits in any column.
  - KEY(c): exactly one low bit across all 16 positions.
  - MULTI: two or more low bits.
- FSM, advancing once per frame:
  - RELEASED:
    - KEY(c) -> cand=c, cnt=1; if DEBOUNCE_SCANS==1, accept immediately (same actions as the accept step in PRESS_DB); otherwise -> PRESS_DB.
    - NONE or MULTI -> stay.
  - PRESS_DB:
    - KEY(cand) -> cnt+1.
    - When cnt reaches DEBOUNCE_SCANS, accept: key_code=cand, key_valid pulses in the same cycle, key_held=1, -> HELD.
    - KEY(other) -> cand=other, cnt=1.
    - NONE or MULTI -> RELEASED, cnt=0.
  - HELD:
    - KEY(key_code) -> stay, cnt=0.
    - Any other result -> cnt=1; if DEBOUNCE_SCANS==1, release immediately (same actions as the release step in RELEASE_DB); otherwise -> RELEASE_DB.
  - RELEASE_DB:
    - Non-matching frames -> cnt+1.
    - When cnt reaches DEBOUNCE_SCANS, release: key_held=0, -> RELEASED; key_code is retained.
    - KEY(key_code) -> HELD, cnt=0.
- Pulse rules:
  - key_valid is exactly one clk cycle per accepted press.
  - A held key never re-pulses; there is no auto-repeat.
  - Rolling to a new key without a full release produces no pulse.
- Reset mid-operation: everything returns to the reset values immediately; a partial frame is discarded.

Optional Feature:
- Macro KYPD_HEX_SHIFT_EN.
- Defined: on each key_valid, data_out <= {data_out[19:0], key_code}, updated in the same cycle as the pulse. Key E clears data_out to 0 instead of shifting. data_out is directly compatible with the display driver's 24-bit data input.
- Undefined: the shift register is omitted and data_out is driven to 24'h0.

Test Plan (SCAN_TICKS=8, DEBOUNCE_SCANS=3, frame=32 cycles):
- Reset, no keys:
  - -> col_n steps 1110, 1101, 1011, 0111 every 8 cycles and wraps.
  - -> key_valid, key_held, key_code and data_out all stay 0.
- Hold key 5 (c1,r1) steady:
  - -> exactly one key_valid pulse, in the evaluation cycle of the 3rd full frame.
  - -> key_code=5 and key_held=1; no further pulses over 10 frames.
- Bounce key 9: pressed 2 frames, released 1, pressed 3 frames.
  - -> no pulse during the first 3 frames.
  - -> one pulse at the end of frame 6, key_code=9.
- Release after holding 5: key absent 2 frames, present 1, absent 3.
  - -> key_held=1 until the 3rd consecutive empty frame, then 0.
  - -> key_code stays 5.
- Keys 1 and 2 pressed together for 5 frames:
  - -> MULTI each frame, no pulse, key_held=0.
  - -> Dropping key 2 gives a pulse with code 1 after 3 frames.
- KYPD_HEX_SHIFT_EN defined:
  - Press 1, 2, 3, each with a full release between -> data_out=24'h000123.
  - Then press E -> data_out=0.
  - Assert rst mid-frame -> all outputs return to reset values the next cycle.
